// File: rtl/iq_cordic_pkg.sv
// Shared types and constants for the IQ magnitude/phase CORDIC: FSM states,
// arctangent table and the shift-add constants of the 1/K gain correction.
package iq_cordic_pkg;

   typedef enum logic [2:0] {IDLE, PRE, ROT, COMP, DONE} state_e;

   localparam int unsigned GC_TERMS = 4;

   // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9
   function automatic int unsigned gc_shift(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         2:       return 6;
         default: return 9;
      endcase
   endfunction

   function automatic logic gc_neg(input int k);
      return (k >= 2);
   endfunction

   // round(atan(2^-i) * 2^16 / (2*pi))
   function automatic logic [31:0] atan_base(input logic [3:0] i);
      case (i)
         4'd0:    return 32'd8192;
         4'd1:    return 32'd4836;
         4'd2:    return 32'd2555;
         4'd3:    return 32'd1297;
         4'd4:    return 32'd651;
         4'd5:    return 32'd326;
         4'd6:    return 32'd163;
         4'd7:    return 32'd81;
         4'd8:    return 32'd41;
         4'd9:    return 32'd20;
         4'd10:   return 32'd10;
         4'd11:   return 32'd5;
         4'd12:   return 32'd3;
         4'd13:   return 32'd1;
         4'd14:   return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] atan_lut(input logic [3:0] i, input int unsigned pw);
      logic [31:0] b;
      b = atan_base(i);
      if (pw >= 32'd16) return b << (pw - 32'd16);
      return (b + (32'd1 << (32'd15 - pw))) >> (32'd16 - pw);
   endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// Combinational 1/K gain correction of the CORDIC x result, with
// round-half-up removal of the guard bits and saturation to N bits.
module cordic_gain_comp
   import iq_cordic_pkg::*;
#(
   parameter int unsigned W = 18,
   parameter int unsigned N = 14,
   parameter int unsigned G = 2
) (
   input  logic signed [W-1:0] x_i,
   output logic        [N-1:0] mag_c_o
);

   localparam int unsigned AW  = W + 1;
   localparam int unsigned RND = (G > 0) ? (1 << (G - 1)) : 0;
   localparam logic signed [AW-1:0] RND_C = AW'(RND);
   localparam logic signed [AW-1:0] MAX_C = AW'((1 << N) - 1);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] term;
   logic signed [AW-1:0] rnd;

   always_comb begin
      acc  = '0;
      term = '0;
      for (int k = 0; k < int'(GC_TERMS); k++) begin
         term = AW'(x_i) >>> gc_shift(k);
         if (gc_neg(k)) acc = acc - term;
         else           acc = acc + term;
      end
      rnd = (acc + RND_C) >>> G;
      if (rnd[AW-1])        mag_c_o = '0;
      else if (rnd > MAX_C) mag_c_o = '1;
      else                  mag_c_o = N'(rnd);
   end

endmodule

// File: rtl/iq_mag_phase_cordic.sv
// Iterative vectoring-mode CORDIC: one signed I/Q pair in, magnitude and
// phase out, one micro-rotation per clock, valid/ready on both sides.
module iq_mag_phase_cordic
   import iq_cordic_pkg::*;
#(
   parameter int unsigned N    = 14,
   parameter int unsigned PW   = 16,
   parameter int unsigned ITER = 14,
   parameter int unsigned G    = 2
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [N-1:0]  I,
   input  logic signed [N-1:0]  Q,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic        [N-1:0]  mag,
   output logic signed [PW-1:0] phase
);

   localparam int unsigned W  = N + 2 + G;
   localparam int unsigned CW = 4;

   state_e               state_q;
   logic                 in_ready_q, out_valid_q, zero_q;
   logic [CW-1:0]        cnt_q;
   logic signed [N-1:0]  i_q, q_q;
   logic signed [W-1:0]  x_q, y_q;
   logic signed [PW-1:0] z_q;
   logic [N-1:0]         mag_q;
   logic signed [PW-1:0] phase_q;

   logic signed [W-1:0]  x_d, y_d, x_sh, y_sh;
   logic signed [PW-1:0] z_d, atan_c;
   logic [N-1:0]         mag_c;

   // Pre-rotation into the right half-plane and per-iteration operands
   always_comb begin
      x_d = W'(i_q) <<< G;
      y_d = W'(q_q) <<< G;
      z_d = '0;
      if (i_q[N-1]) begin
         x_d = -x_d;
         y_d = -y_d;
         z_d = {1'b1, {(PW-1){1'b0}}};
      end
      x_sh   = x_q >>> cnt_q;
      y_sh   = y_q >>> cnt_q;
      atan_c = PW'(atan_lut(cnt_q, PW));
   end

   cordic_gain_comp #(.W(W), .N(N), .G(G)) u_gain (
      .x_i     (x_q),
      .mag_c_o (mag_c)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         mag_q       <= '0;
         phase_q     <= '0;
         cnt_q       <= '0;
         zero_q      <= 1'b0;
         i_q         <= '0;
         q_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
               i_q        <= I;
               q_q        <= Q;
               in_ready_q <= 1'b0;
               state_q    <= PRE;
            end
            PRE: begin
               x_q     <= x_d;
               y_q     <= y_d;
               z_q     <= z_d;
               zero_q  <= (i_q == '0) && (q_q == '0);
               cnt_q   <= '0;
               state_q <= ROT;
            end
            ROT: begin
               if (!y_q[W-1]) begin
                  x_q <= x_q + y_sh;
                  y_q <= y_q - x_sh;
                  z_q <= z_q + atan_c;
               end else begin
                  x_q <= x_q - y_sh;
                  y_q <= y_q + x_sh;
                  z_q <= z_q - atan_c;
               end
               if (cnt_q == CW'(ITER - 1)) state_q <= COMP;
               else                        cnt_q   <= cnt_q + 1'b1;
            end
            COMP: begin
               mag_q       <= zero_q ? '0 : mag_c;
               phase_q     <= zero_q ? '0 : z_q;
               out_valid_q <= 1'b1;
               cnt_q       <= '0;
               state_q     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign mag       = mag_q;
   assign phase     = phase_q;

endmodule

// File: tb/tb_iq_mag_phase_cordic.sv
// Self-checking bench for iq_mag_phase_cordic: directed table, random pairs
// against a real-arithmetic sqrt/atan2 model, backpressure and reset abort.
module tb_iq_mag_phase_cordic;

   localparam int unsigned N    = 14;
   localparam int unsigned PW   = 16;
   localparam int unsigned ITER = 14;
   localparam real PI = 3.14159265358979;

   logic                 CLK = 1'b0;
   logic                 reset = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 out_ready = 1'b1;
   logic signed [N-1:0]  I = '0;
   logic signed [N-1:0]  Q = '0;
   logic                 in_ready, out_valid;
   logic [N-1:0]         mag;
   logic signed [PW-1:0] phase;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int i;
      int q;
      int m;
      int mt;
      int p;
      int pt;
   } vec_t;

   vec_t tbl [8];

   iq_mag_phase_cordic #(.N(N), .PW(PW), .ITER(ITER), .G(2)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .I         (I),
      .Q         (Q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag       (mag),
      .phase     (phase)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp, input int tol);
      int d;
      d = act - exp;
      vectors++;
      if (d > tol || d < -tol) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   // Phase compare modulo a full circle
   task automatic chk_ph(input string name, input int act, input int exp, input int tol);
      int d;
      d = (((act - exp) % 65536) + 65536 + 32768) % 65536 - 32768;
      vectors++;
      if (d > tol || d < -tol) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d +/- %0d (mod 65536)", name, act, exp, tol);
      end
   endtask

   // Called just after the accepting edge; returns result and edges to out_valid
   task automatic wait_result(output int m, output int p, output int lat);
      I = N'($urandom);
      Q = N'($urandom);
      lat = 0;
      while (!out_valid && lat < 200) begin
         if (lat == 3) in_valid = 1'b0;
         @(posedge CLK); #1;
         lat++;
      end
      in_valid = 1'b0;
      if (!out_valid) chk("out_valid_timeout", 0, 1, 0);
      m = int'(mag);
      p = int'(phase);
   endtask

   task automatic send(input int ii, input int qq, output int m, output int p, output int lat);
      int g;
      g = 0;
      while (!in_ready && g < 200) begin
         @(posedge CLK); #1;
         g++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1, 0);
      in_valid = 1'b1;
      I = N'(ii);
      Q = N'(qq);
      @(posedge CLK); #1;
      wait_result(m, p, lat);
   endtask

   function automatic int ref_mag(input int ii, input int qq);
      return int'($sqrt(real'(ii) * real'(ii) + real'(qq) * real'(qq)));
   endfunction

   function automatic int ref_ph(input int ii, input int qq);
      return int'($atan2(real'(qq), real'(ii)) * 32768.0 / PI);
   endfunction

   initial begin
      int m, p, lat, ii, qq, rm, changes, hits;

      tbl[0] = '{4000,     0,  4000, 3,      0, 2};
      tbl[1] = '{   0,  4000,  4000, 3,  16384, 2};
      tbl[2] = '{   0, -4000,  4000, 3, -16384, 2};
      tbl[3] = '{-4000,    0,  4000, 3, -32768, 2};
      tbl[4] = '{-8192, -8192, 11585, 8, -24576, 2};
      tbl[5] = '{   0,     0,     0, 0,      0, 0};
      tbl[6] = '{2828,  2828,  3999, 3,   8192, 2};
      tbl[7] = '{3000, -4000,  5000, 4,  -9672, 3};

      @(posedge CLK); @(posedge CLK); #1;
      chk("reset_in_ready", int'(in_ready), 1, 0);
      chk("reset_out_valid", int'(out_valid), 0, 0);
      chk("reset_mag", int'(mag), 0, 0);
      chk("reset_phase", int'(phase), 0, 0);
      reset = 1'b0;

      for (int k = 0; k < 8; k++) begin
         send(tbl[k].i, tbl[k].q, m, p, lat);
         chk("latency", lat, int'(ITER) + 2, 0);
         chk("tbl_mag", m, tbl[k].m, tbl[k].mt);
         chk_ph("tbl_phase", p, tbl[k].p, tbl[k].pt);
         chk("busy_in_ready", int'(in_ready), 0, 0);
         @(posedge CLK); #1;
      end

      for (int k = 0; k < 40; k++) begin
         do begin
            ii = int'($urandom_range(16383)) - 8192;
            qq = int'($urandom_range(16383)) - 8192;
         end while (ii * ii + qq * qq < 4000000);
         send(ii, qq, m, p, lat);
         rm = ref_mag(ii, qq);
         chk("rnd_mag", m, rm, rm * 6 / 10000 + 3);
         chk_ph("rnd_phase", p, ref_ph(ii, qq), 4);
         @(posedge CLK); #1;
      end

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      send(1500, -2500, m, p, lat);
      chk("bp_mag", m, ref_mag(1500, -2500), 3);
      chk_ph("bp_phase", p, ref_ph(1500, -2500), 3);
      changes = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK); #1;
         if (!out_valid || in_ready || int'(mag) != m || int'(phase) != p) changes++;
      end
      chk("bp_hold_changes", changes, 0, 0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      I = N'(2000);
      Q = N'(1000);
      @(posedge CLK); #1;
      chk("bp_release_out_valid", int'(out_valid), 0, 0);
      chk("bp_release_in_ready", int'(in_ready), 1, 0);
      @(posedge CLK); #1;
      chk("bp_accept_in_ready", int'(in_ready), 0, 0);
      wait_result(m, p, lat);
      chk("bp_next_latency", lat, int'(ITER) + 2, 0);
      chk("bp_next_mag", m, ref_mag(2000, 1000), 3);
      chk_ph("bp_next_phase", p, ref_ph(2000, 1000), 3);
      @(posedge CLK); #1;

      // Reset in the fifth ROT cycle aborts the computation
      in_valid = 1'b1;
      I = N'(-1234);
      Q = N'(3456);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      chk("abort_in_ready", int'(in_ready), 1, 0);
      chk("abort_out_valid", int'(out_valid), 0, 0);
      chk("abort_mag", int'(mag), 0, 0);
      chk("abort_phase", int'(phase), 0, 0);
      hits = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge CLK); #1;
         if (out_valid) hits++;
      end
      chk("abort_no_out_valid", hits, 0, 0);
      send(-3000, 1200, m, p, lat);
      chk("post_abort_latency", lat, int'(ITER) + 2, 0);
      chk("post_abort_mag", m, ref_mag(-3000, 1200), 3);
      chk_ph("post_abort_phase", p, ref_ph(-3000, 1200), 3);
      @(posedge CLK); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
